// File: rtl/fp_accumulator_pkg.sv
// Shared binary32 constants, FSM state encoding and classification helpers
// for the streaming float accumulator and its adder.
package fp_accumulator_pkg;

    localparam int          FP_WIDTH    = 32;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == FP_EXP_MAX) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == FP_EXP_MAX) && (v[22:0] == 23'd0);
    endfunction

    // Leading-zero count of a 27-bit significand; 27 when the value is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] lz;
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lz = 5'(26 - i);
        end
        return lz;
    endfunction

endpackage

// File: rtl/fp_accumulator_adder.sv
// Combinational binary32 adder, round-to-nearest-even with full subnormal
// support; overflow flags a finite+finite sum that rounds to infinity.
module fp_accumulator_adder
    import fp_accumulator_pkg::*;
(
    input  logic [FP_WIDTH-1:0] x,
    input  logic [FP_WIDTH-1:0] y,
    output logic [FP_WIDTH-1:0] result,
    output logic                overflow
);

    logic [31:0] w_a, w_b;
    logic [7:0]  w_ea, w_eb, w_diff;
    logic [26:0] w_ma, w_mb, w_mb_sh, w_norm;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [9:0]  w_exp, w_exp_r;
    logic [24:0] w_mr;
    logic [23:0] w_mant;
    logic        w_eff_sub, w_rnd;

    always_comb begin
        // Order operands by magnitude so the aligned subtraction never goes negative.
        if (y[30:0] > x[30:0]) begin
            w_a = y;
            w_b = x;
        end else begin
            w_a = x;
            w_b = y;
        end
        w_ea      = (w_a[30:23] == 8'd0) ? 8'd1 : w_a[30:23];
        w_eb      = (w_b[30:23] == 8'd0) ? 8'd1 : w_b[30:23];
        w_ma      = {(w_a[30:23] != 8'd0), w_a[22:0], 3'b000};
        w_mb      = {(w_b[30:23] != 8'd0), w_b[22:0], 3'b000};
        w_diff    = w_ea - w_eb;
        w_eff_sub = w_a[31] ^ w_b[31];

        if (w_diff > 8'd26) begin
            w_mb_sh = {26'd0, (w_mb != 27'd0)};
        end else begin
            w_mb_sh    = w_mb >> w_diff;
            w_mb_sh[0] = w_mb_sh[0] | ((w_mb & ~(27'h7FF_FFFF << w_diff)) != 27'd0);
        end

        w_sum = w_eff_sub ? ({1'b0, w_ma} - {1'b0, w_mb_sh})
                          : ({1'b0, w_ma} + {1'b0, w_mb_sh});
        w_lz  = lzc27(w_sum[26:0]);

        // Left normalisation stops at exponent 1, leaving a subnormal in place.
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = {2'b00, w_ea} + 10'd1;
        end else if ({3'b000, w_lz} < w_ea) begin
            w_norm = w_sum[26:0] << w_lz;
            w_exp  = {2'b00, w_ea - {3'b000, w_lz}};
        end else begin
            w_norm = w_sum[26:0] << (w_ea - 8'd1);
            w_exp  = 10'd1;
        end

        w_rnd = w_norm[2] & ((w_norm[1:0] != 2'b00) | w_norm[3]);
        w_mr  = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
        if (w_mr[24]) begin
            w_mant  = w_mr[24:1];
            w_exp_r = w_exp + 10'd1;
        end else begin
            w_mant  = w_mr[23:0];
            w_exp_r = w_exp;
        end

        overflow = 1'b0;
        if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && (x[31] != y[31]))) begin
            result = FP_QNAN;
        end else if (is_inf(x)) begin
            result = x;
        end else if (is_inf(y)) begin
            result = y;
        end else if (w_sum == 28'd0) begin
            result = {~w_eff_sub & w_a[31], 31'd0};
        end else if (w_exp_r >= 10'd255) begin
            result   = {w_a[31], FP_POS_INF[30:0]};
            overflow = 1'b1;
        end else begin
            result = {w_a[31], (w_mant[23] ? w_exp_r[7:0] : 8'd0), w_mant[22:0]};
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Streaming binary32 accumulator: sums a run of count operands through one
// combinational adder and presents the sum with sticky overflow/NaN flags.
module fp_accumulator
    import fp_accumulator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic             out_nan,
    output logic             busy
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CNT_W-1:0] r_remaining, w_rem_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_nan, w_nan_nxt;
    logic [WIDTH-1:0] w_add_result;
    logic             w_add_ovf;

    fp_accumulator_adder u_add (
        .x        (r_acc),
        .y        (in_data),
        .result   (w_add_result),
        .overflow (w_add_ovf)
    );

    always_comb begin
        // NOTE: every next-state value defaults to its current register first, so no path infers a latch.
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_remaining;
        w_ovf_nxt   = r_ovf;
        w_nan_nxt   = r_nan;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt = FP_POS_ZERO;
                    w_ovf_nxt = 1'b0;
                    w_nan_nxt = 1'b0;
                    if (count != '0) begin
                        w_rem_nxt   = count;
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    w_acc_nxt = w_add_result;
                    w_ovf_nxt = r_ovf | w_add_ovf;
                    w_nan_nxt = r_nan | is_nan(w_add_result);
                    w_rem_nxt = r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= FP_POS_ZERO;
            r_remaining <= '0;
            r_ovf       <= 1'b0;
            r_nan       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_remaining <= w_rem_nxt;
            r_ovf       <= w_ovf_nxt;
            r_nan       <= w_nan_nxt;
        end
    end

    assign in_ready     = (r_state == S_ACCUM);
    assign out_valid    = (r_state == S_DONE);
    assign busy         = (r_state == S_ACCUM) || (r_state == S_DONE);
    assign out_data     = r_acc;
    assign out_overflow = r_ovf;
    assign out_nan      = r_nan;

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: directed cases plus random runs
// checked against a real-arithmetic binary32 reference model.
module tb_fp_accumulator;

    logic        clk, rst, start, in_valid, in_ready, out_valid, out_ready;
    logic        out_overflow, out_nan, busy;
    logic [7:0]  count;
    logic [31:0] in_data, out_data;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] g_ops[$];

    fp_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .count        (count),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_nan      (out_nan),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic m_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [31:0] v);
        int  e;
        real m;
        e = int'(v[30:23]);
        m = real'(int'(v[22:0]));
        if (e == 0) m = m * pow2(-149);
        else        m = (m + 8388608.0) * pow2(e - 150);
        return v[31] ? -m : m;
    endfunction

    // Round a real (exact or double-rounded sum of two floats) to binary32, RNE.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] rb;
        logic        s;
        real         a, n, fr;
        int          e, qe, fl, be;
        rb = $realtobits(r);
        s  = rb[63];
        a  = s ? -r : r;
        if (a == 0.0) return {s, 31'd0};
        e = 0;
        while (a >= pow2(e + 1)) e++;
        while (a < pow2(e)) e--;
        qe = (e < -126) ? -149 : e - 23;
        n  = a / pow2(qe);
        fl = $rtoi(n);
        fr = n - real'(fl);
        if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == 16777216) begin
            fl = 8388608;
            qe++;
        end
        if (fl < 8388608) return {s, 8'd0, fl[22:0]};
        be = qe + 150;
        if (be >= 255) return {s, 8'hFF, 23'd0};
        return {s, be[7:0], fl[22:0]};
    endfunction

    task automatic model_add(input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] r, output logic ovf);
        ovf = 1'b0;
        if (m_nan(x) || m_nan(y) || (m_inf(x) && m_inf(y) && x[31] != y[31])) begin
            r = 32'h7FC0_0000;
        end else if (m_inf(x)) begin
            r = x;
        end else if (m_inf(y)) begin
            r = y;
        end else begin
            r   = r2f(f2r(x) + f2r(y));
            ovf = m_inf(r);
        end
    endtask

    function automatic logic [31:0] rand_op(input int mode);
        int         k;
        logic [7:0] e;
        logic [2:0] pick;
        k = $urandom_range(99, 0);
        if (mode == 2 && k < 4) begin
            pick = 3'($urandom_range(2, 0));
            case (pick)
                3'd0:    return 32'h7FC0_0000;
                3'd1:    return 32'h7F80_0000;
                default: return 32'hFF80_0000;
            endcase
        end
        if (mode == 1)      e = 8'($urandom_range(1, 0));
        else if (k < 10)    e = 8'($urandom_range(254, 252));
        else                e = 8'($urandom_range(135, 120));
        return {1'($urandom_range(1, 0)), e, 23'($urandom)};
    endfunction

    task automatic check_result(input string tag, input logic [31:0] acc,
                                input logic ovf_m, input logic nan_m);
        if (nan_m && m_nan(acc)) check({tag, "_isnan"}, 32'(m_nan(out_data)), 32'd1);
        else                     check({tag, "_data"}, out_data, acc);
        check({tag, "_ovf"}, 32'(out_overflow), 32'(ovf_m));
        check({tag, "_nanflag"}, 32'(out_nan), 32'(nan_m));
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    // Runs g_ops as one accumulation; entered and left on a negedge in IDLE.
    task automatic run_ops(input int gmin, input int gmax, input int hold,
                           input bit use_want, input logic [31:0] want);
        logic [31:0] acc, r;
        logic        ovf_m, nan_m, o;
        int          n;
        n     = g_ops.size();
        acc   = 32'd0;
        ovf_m = 1'b0;
        nan_m = 1'b0;
        foreach (g_ops[i]) begin
            model_add(acc, g_ops[i], r, o);
            acc   = r;
            ovf_m = ovf_m | o;
            nan_m = nan_m | m_nan(r);
        end
        check("idle_ready", 32'(in_ready), 32'd0);
        check("idle_valid", 32'(out_valid), 32'd0);
        start = 1'b1;
        count = 8'(n);
        @(negedge clk);
        start = 1'b0;
        count = 8'($urandom);
        check("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(gmax, gmin);
            for (int g = 0; g < gap; g++) begin
                in_data   = $urandom;
                out_ready = 1'($urandom);
                check("gap_ready", 32'(in_ready), 32'd1);
                check("gap_valid", 32'(out_valid), 32'd0);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = g_ops[i];
            check("beat_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
        check_result("done", acc, ovf_m, nan_m);
        if (use_want) check("want_data", out_data, want);
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            count = 8'd5;
            @(negedge clk);
            check_result("hold", acc, ovf_m, nan_m);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_valid", 32'(out_valid), 32'd0);
        check("retire_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("idle2_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        count     = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        check("rst_nan", 32'(out_nan), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        g_ops = {};
        for (int i = 0; i < 4; i++) g_ops.push_back(32'h3F80_0000);
        run_ops(0, 0, 0, 1'b1, 32'h4080_0000);

        g_ops = {};
        g_ops.push_back(32'h3F80_0000);
        g_ops.push_back(32'hBF80_0000);
        run_ops(3, 3, 0, 1'b1, 32'h0000_0000);

        g_ops = {};
        g_ops.push_back(32'h7F7F_FFFF);
        g_ops.push_back(32'h7F7F_FFFF);
        run_ops(0, 1, 5, 1'b1, 32'h7F80_0000);
        check("t3_ovf", 32'(out_overflow), 32'd1);

        g_ops = {};
        g_ops.push_back(32'h3F80_0000);
        g_ops.push_back(32'h7FC0_0000);
        g_ops.push_back(32'h3F80_0000);
        run_ops(0, 1, 0, 1'b0, 32'd0);
        check("t4_nan", 32'(out_nan), 32'd1);
        check("t4_exp", 32'(out_data[30:23]), 32'h0000_00FF);

        g_ops = {};
        run_ops(0, 0, 2, 1'b1, 32'h0000_0000);

        start = 1'b1;
        count = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h4000_0000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        g_ops = {};
        g_ops.push_back(32'h3F00_0000);
        run_ops(0, 0, 0, 1'b1, 32'h3F00_0000);

        for (int r = 0; r < 40; r++) begin
            int mode, n;
            mode  = $urandom_range(2, 0);
            n     = $urandom_range(10, 1);
            g_ops = {};
            for (int i = 0; i < n; i++) g_ops.push_back(rand_op(mode));
            run_ops(0, 2, $urandom_range(2, 0), 1'b0, 32'd0);
        end

        g_ops = {};
        for (int i = 0; i < 255; i++) g_ops.push_back(rand_op(0));
        run_ops(0, 0, 0, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
